vanilla_rr_lock_arb: RTL and testbench

Parameterized round-robin arbiter with transaction locking. It shares one single-ported resource (e.g. the shared FPU or remote-store port of the vanilla core) among `num_reqs_p` requesters. A requester that wins keeps ownership across a multi-beat transaction until it presents its last beat. Priority rotates past the owner only when the transaction completes, and a beat limit guards against a requester that never sends `last`.

---
 rtl/vanilla_arb_pkg.sv | 9 +
 rtl/vanilla_rr_pick.sv | 29 ++
 rtl/vanilla_rr_lock_arb.sv | 115 +++++++++++
 tb/tb_vanilla_rr_lock_arb.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/vanilla_arb_pkg.sv
// Shared types for the vanilla core arbiters.
package vanilla_arb_pkg;

  typedef enum logic [0:0] {
    eIdle   = 1'b0,
    eLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vanilla_rr_pick.sv
// Rotating priority encoder: picks the first set request after 'last', wrapping
// modulo num_reqs_p. Purely combinational so arbiters get zero-cycle grants.
module vanilla_rr_pick #(
  parameter int num_reqs_p = 4,
  parameter int id_width_lp = $clog2(num_reqs_p)
) (
  input  logic [num_reqs_p-1:0]  reqs,
  input  logic [id_width_lp-1:0] last,
  output logic [id_width_lp-1:0] sel_id,
  output logic                   found
);

  int idx;

  // Search starts one past the previous winner so that winner has lowest priority.
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= num_reqs_p; i++) begin
      idx = (int'(last) + i) % num_reqs_p;
      if (!found && reqs[idx]) begin
        found  = 1'b1;
        sel_id = id_width_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/vanilla_rr_lock_arb.sv
// Round-robin arbiter that locks onto a winner for a multi-beat transaction,
// with a beat limit that forces release from a requester that never ends.
module vanilla_rr_lock_arb
  import vanilla_arb_pkg::*;
#(
  parameter int num_reqs_p  = 4,
  parameter int max_beats_p = 4,
  parameter int id_width_lp = $clog2(num_reqs_p),
  parameter int cnt_width_lp = $clog2(max_beats_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_reqs_p-1:0]  v_i,
  input  logic [num_reqs_p-1:0]  last_i,
  input  logic                   ready_i,
  output logic [num_reqs_p-1:0]  yumi_o,
  output logic                   v_o,
  output logic [id_width_lp-1:0] sel_id_o,
  output logic                   locked_o,
  output logic                   err_o
);

  arb_state_e                state_r, state_d;
  logic [id_width_lp-1:0]    owner_r, owner_d;
  logic [id_width_lp-1:0]    last_r, last_d;
  logic [cnt_width_lp-1:0]   beat_cnt_r, beat_cnt_d;
  logic                      err_r, err_d;

  logic [id_width_lp-1:0]    pick_id;
  logic                      pick_found;
  logic [id_width_lp-1:0]    cand;
  logic                      xfer;
  logic                      cand_last;

  vanilla_rr_pick #(
    .num_reqs_p (num_reqs_p)
  ) pick (
    .reqs   (v_i),
    .last   (last_r),
    .sel_id (pick_id),
    .found  (pick_found)
  );

  // While locked only the owner can be presented, even if others are valid.
  always_comb begin
    if (state_r == eLocked) begin
      cand = owner_r;
      v_o  = v_i[owner_r];
    end else begin
      cand = pick_id;
      v_o  = pick_found;
    end
    xfer      = v_o & ready_i;
    cand_last = last_i[cand];
    sel_id_o  = cand;
    yumi_o    = '0;
    if (xfer) yumi_o[cand] = 1'b1;
  end

  always_comb begin
    state_d    = state_r;
    owner_d    = owner_r;
    last_d     = last_r;
    beat_cnt_d = beat_cnt_r;
    err_d      = 1'b0;
    if (xfer) begin
      if (state_r == eIdle) begin
        if (cand_last) begin
          last_d = cand;
        end else if (max_beats_p == 1) begin
          last_d = cand;
          err_d  = 1'b1;
        end else begin
          owner_d    = cand;
          beat_cnt_d = cnt_width_lp'(1);
          state_d    = eLocked;
        end
      end else begin
        if (cand_last) begin
          last_d     = owner_r;
          beat_cnt_d = '0;
          state_d    = eIdle;
        end else if (beat_cnt_r + 1'b1 == cnt_width_lp'(max_beats_p)) begin
          last_d     = owner_r;
          beat_cnt_d = '0;
          state_d    = eIdle;
          err_d      = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_r + 1'b1;
        end
      end
    end
  end

  // Reset points last_r at the top requester so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eIdle;
      owner_r    <= '0;
      last_r     <= id_width_lp'(num_reqs_p - 1);
      beat_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_d;
      owner_r    <= owner_d;
      last_r     <= last_d;
      beat_cnt_r <= beat_cnt_d;
      err_r      <= err_d;
    end
  end

  assign locked_o = (state_r == eLocked);
  assign err_o    = err_r;

endmodule

// File: tb/tb_vanilla_rr_lock_arb.sv
// Directed bench for vanilla_rr_lock_arb with hand-computed expected grants.
module tb_vanilla_rr_lock_arb;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] v_i;
  logic [3:0] last_i;
  logic       ready_i;
  logic [3:0] yumi_o;
  logic       v_o;
  logic [1:0] sel_id_o;
  logic       locked_o;
  logic       err_o;

  int tests_run  = 0;
  int fail_count = 0;

  vanilla_rr_lock_arb #(
    .num_reqs_p  (4),
    .max_beats_p (4)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .last_i   (last_i),
    .ready_i  (ready_i),
    .yumi_o   (yumi_o),
    .v_o      (v_o),
    .sel_id_o (sel_id_o),
    .locked_o (locked_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst, input logic [3:0] v,
                               input logic [3:0] lst, input logic rdy);
    @(negedge clk_i);
    reset_i = rst;
    v_i     = v;
    last_i  = lst;
    ready_i = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = '0;
    last_i  = '0;
    ready_i = 1'b0;

    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    checkOutput("rst_v_o", 32'(v_o), 32'd0);
    checkOutput("rst_yumi", 32'(yumi_o), 32'd0);
    checkOutput("rst_sel", 32'(sel_id_o), 32'd0);
    checkOutput("rst_locked", 32'(locked_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_v_o", 32'(v_o), 32'd0);
    checkOutput("idle_yumi", 32'(yumi_o), 32'd0);

    // Fair rotation with everyone valid and single-beat.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
      checkOutput($sformatf("rr_yumi_%0d", k), 32'(yumi_o), 32'(4'b0001 << (k % 4)));
      checkOutput($sformatf("rr_locked_%0d", k), 32'(locked_o), 32'd0);
    end

    // Requester 1 alone so requester 2 is next in line.
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1);
    checkOutput("pre_yumi", 32'(yumi_o), 32'b0010);

    // Requester 2: three-beat transaction while all requesters are valid.
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);
    checkOutput("lk_b1_yumi", 32'(yumi_o), 32'b0100);
    checkOutput("lk_b1_locked", 32'(locked_o), 32'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);
    checkOutput("lk_b2_yumi", 32'(yumi_o), 32'b0100);
    checkOutput("lk_b2_locked", 32'(locked_o), 32'd1);
    applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b1);
    checkOutput("lk_b3_yumi", 32'(yumi_o), 32'b0100);
    checkOutput("lk_b3_locked", 32'(locked_o), 32'd1);
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
    checkOutput("lk_next_yumi", 32'(yumi_o), 32'b1000);
    checkOutput("lk_next_locked", 32'(locked_o), 32'd0);

    // Requester 1 locks, then the resource stalls for five cycles.
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
    checkOutput("bp_start_yumi", 32'(yumi_o), 32'b0010);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
      checkOutput($sformatf("bp_yumi_%0d", k), 32'(yumi_o), 32'd0);
      checkOutput($sformatf("bp_sel_%0d", k), 32'(sel_id_o), 32'd1);
      checkOutput($sformatf("bp_locked_%0d", k), 32'(locked_o), 32'd1);
      checkOutput($sformatf("bp_v_o_%0d", k), 32'(v_o), 32'd1);
    end
    applyStimulus(1'b0, 4'b1111, 4'b0010, 1'b1);
    checkOutput("bp_resume_yumi", 32'(yumi_o), 32'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOutput("bp_done_locked", 32'(locked_o), 32'd0);

    // Requester 0 never sends last; the fourth beat forces a release.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
      checkOutput($sformatf("lim_yumi_%0d", k), 32'(yumi_o), 32'b0001);
      checkOutput($sformatf("lim_locked_%0d", k), 32'(locked_o), (k == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("lim_err_%0d", k), 32'(err_o), 32'd0);
    end
    applyStimulus(1'b0, 4'b0011, 4'b0011, 1'b1);
    checkOutput("lim_err_pulse", 32'(err_o), 32'd1);
    checkOutput("lim_rel_locked", 32'(locked_o), 32'd0);
    checkOutput("lim_next_yumi", 32'(yumi_o), 32'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    checkOutput("lim_err_clear", 32'(err_o), 32'd0);

    // Requester 3 locks, then a one-cycle reset drops the lock.
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1);
    checkOutput("rml_yumi", 32'(yumi_o), 32'b1000);
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);
    checkOutput("rml_locked", 32'(locked_o), 32'd1);
    applyStimulus(1'b1, 4'b1001, 4'b1001, 1'b1);
    applyStimulus(1'b0, 4'b1001, 4'b1001, 1'b1);
    checkOutput("rml_after_locked", 32'(locked_o), 32'd0);
    checkOutput("rml_after_yumi", 32'(yumi_o), 32'b0001);

    // Only requester 3 requests; it must be granted every cycle.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b1);
      checkOutput($sformatf("sparse_yumi_%0d", k), 32'(yumi_o), 32'b1000);
      checkOutput($sformatf("sparse_sel_%0d", k), 32'(sel_id_o), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
